// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, FSM state codes, operand classes and helpers for the FP multiplier
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int SW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int CW = $clog2(MAN_W + 1);
  localparam logic signed [SW-1:0] EMAX = SW'(2 ** EXP_W - 1);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXP = 3'd1;
  localparam logic [2:0] ST_MUL = 3'd2;
  localparam logic [2:0] ST_NORM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} cls_t;
  function automatic cls_t classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    e = x[W-2:MAN_W];
    return (e == '0) ? CL_ZERO : !(&e) ? CL_NORM : (x[MAN_W-1:0] != '0) ? CL_NAN : CL_INF;
  endfunction
endpackage

// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if: operand/result handshake bundle for the FP multiplier
interface fp_mul_seq_if;
  import fp_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, ovf, unf, inv, busy;
  logic [W-1:0] a, b, result;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, result, ovf, unf, inv, busy);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, result, ovf, unf, inv, busy);
endinterface

// File: rtl/fp_exp_add.sv
// fp_exp_add: signed biased exponent sum and result exponent range check
module fp_exp_add
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0]     ea_i,
  input  logic [EXP_W-1:0]     eb_i,
  input  logic signed [SW-1:0] s_i,
  output logic signed [SW-1:0] sum_o,
  output logic                 ovf_o,
  output logic                 unf_o
);
  assign sum_o = SW'(ea_i) + SW'(eb_i) - SW'(BIAS);
  assign ovf_o = s_i >= EMAX;
  assign unf_o = s_i <= 0;
endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential single-precision multiplier with shift-add mantissa core
module fp_mul_seq
  import fp_pkg::*;
(
  input logic clk,
  input logic rst,
  fp_mul_seq_if.slave bus
);
  logic [2:0] state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic sign_q, sign_d, ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
  logic signed [SW-1:0] s_q, s_d, sum, s_adj;
  logic [PW-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [MAN_W:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rng_ovf, rng_unf, carry, is_nan, is_inf, is_zero;
  logic [MAN_W-1:0] man_n;
  logic [W-1:0] inf_res, zero_res, spec_res, norm_res;
  cls_t ca, cb;
  fp_exp_add u_exp (
    .ea_i(a_q[W-2:MAN_W]), .eb_i(b_q[W-2:MAN_W]), .s_i(s_adj),
    .sum_o(sum), .ovf_o(rng_ovf), .unf_o(rng_unf)
  );
  assign ca = classify(a_q);
  assign cb = classify(b_q);
  assign is_nan = ca == CL_NAN || cb == CL_NAN || (ca == CL_INF && cb == CL_ZERO) || (ca == CL_ZERO && cb == CL_INF);
  assign is_inf = ca == CL_INF || cb == CL_INF;
  assign is_zero = ca == CL_ZERO || cb == CL_ZERO;
  assign inf_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_res = {sign_q, {(W-1){1'b0}}};
  assign spec_res = is_nan ? CANON_NAN : is_inf ? inf_res : zero_res;
  assign carry = acc_q[PW-1];
  assign s_adj = s_q + {{(SW-1){1'b0}}, carry};
  assign man_n = carry ? acc_q[PW-2:MAN_W+1] : acc_q[PW-3:MAN_W];
  assign norm_res = rng_ovf ? inf_res : rng_unf ? zero_res : {sign_q, s_adj[EXP_W-1:0], man_n};
  assign bus.in_ready = state_q == ST_IDLE;
  assign bus.out_valid = state_q == ST_DONE;
  assign bus.busy = state_q != ST_IDLE;
  assign bus.result = res_q;
  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
  assign bus.inv = inv_q;
  // next-state and datapath: accept, classify, shift-add, normalise, hold
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sign_d = sign_q;
    s_d = s_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    inv_d = inv_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        state_d = ST_EXP;
        a_d = bus.a;
        b_d = bus.b;
        sign_d = bus.a[W-1] ^ bus.b[W-1];
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inv_d = 1'b0;
      end
      ST_EXP: if (is_nan || is_inf || is_zero) begin
        state_d = ST_DONE;
        res_d = spec_res;
        inv_d = is_nan;
      end else begin
        state_d = ST_MUL;
        s_d = sum;
        mcand_d = PW'({1'b1, a_q[MAN_W-1:0]});
        mplier_d = {1'b1, b_q[MAN_W-1:0]};
        acc_d = '0;
        cnt_d = '0;
      end
      ST_MUL: begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(MAN_W)) ? ST_NORM : ST_MUL;
      end
      ST_NORM: begin
        state_d = ST_DONE;
        res_d = norm_res;
        ovf_d = rng_ovf;
        unf_d = rng_unf;
      end
      ST_DONE: state_d = bus.out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      sign_q <= 1'b0;
      s_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sign_q <= sign_d;
      s_q <= s_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inv_q <= inv_d;
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vectors for the sequential FP multiplier
module tb_fp_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  fp_mul_seq_if bus();
  fp_mul_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [31:0] av, input logic [31:0] bv);
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] er, input logic [2:0] ef, input int el);
    int n;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    start(av, bv);
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    wait_done(n);
    check({tag, " latency"}, n, el);
    check({tag, " result"}, bus.result, er);
    check({tag, " flags"}, 32'({bus.ovf, bus.unf, bus.inv}), 32'(ef));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready rise"}, 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    int n;
    logic [31:0] held;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst result", bus.result, 32'h0);
    check("rst flags", 32'({bus.ovf, bus.unf, bus.inv}), 32'd0);
    run("basic", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26);
    run("carry", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26);
    run("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 26);
    run("unf", 32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 26);
    run("inf*0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1);
    run("-inf*2", 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1);
    run("-0*1", 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1);
    run("nan*1", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 1);
    run("neg", 32'hBFC00000, 32'h40000000, 32'hC0400000, 3'b000, 26);
    start(32'h3FC00000, 32'h40000000);
    wait_done(n);
    check("bp latency", n, 26);
    held = 32'h40400000;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a = 32'h7F800000;
      bus.b = 32'h00000000;
      @(posedge clk);
      #1;
      check("bp result", bus.result, held);
      check("bp flags", 32'({bus.ovf, bus.unf, bus.inv}), 32'd0);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp idle in_ready", 32'(bus.in_ready), 32'd1);
    check("bp idle out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp no stray accept", 32'(bus.busy), 32'd0);
    start(32'h3FC00000, 32'h40000000);
    repeat (11) @(posedge clk);
    #1;
    check("mid busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
    check("mid rst busy", 32'(bus.busy), 32'd0);
    check("mid rst result", bus.result, 32'h0);
    check("mid rst flags", 32'({bus.ovf, bus.unf, bus.inv}), 32'd0);
    run("after rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Sequential single-precision (IEEE-754 style) floating-point multiplier controller.
- Accepts one operand pair over a valid/ready handshake and classifies special operands.
- Sequences a biased exponent-add stage, an iterative 1-bit-per-cycle mantissa multiplier and a normalise/range-check stage.
- Presents the result over a valid/ready output handshake. Sits between the operand source and the FP result consumer.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width; hidden bit is implicit.
- BIAS, 2**(EXP_W-1)-1 (127), exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, man}.
- b  in  1+EXP_W+MAN_W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+MAN_W  product.
- ovf  out  1  overflow; result forced to signed infinity.
- unf  out  1  underflow; result flushed to signed zero.
- inv  out  1  invalid op; result is canonical NaN.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; ovf=unf=inv=0.
- rst mid-operation: next edge returns to IDLE. Partial product is discarded and no output is produced.
- States: IDLE, EXP, MUL, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b; sign = a.s^b.s; go to EXP.
- EXP (1 cycle): classify operands. exp==0 is treated as zero (denormals are flushed); exp all-ones with man!=0 is NaN.
  - Any NaN, or inf*zero -> result=canonical NaN (0x7FC00000 at default widths), inv=1, go to DONE.
  - inf*nonzero -> {sign, all-ones, 0}, no flag, go to DONE.
  - Zero operand -> {sign, 0, 0}, no flag, go to DONE.
  - Otherwise:
    - s = eA + eB - BIAS, held signed in EXP_W+2 bits.
    - Load multiplicand/multiplier {1, man}; clear the 2*(MAN_W+1)-bit accumulator; counter=0; go to MUL.
- MUL (MAN_W+1 cycles, 24 at default):
  - Shift-add one multiplier bit per cycle; counter increments.
  - When counter==MAN_W, go to NORM.
- NORM (1 cycle):
  - If prod[2*MAN_W+1] is set: s+=1, man = prod[2*MAN_W:MAN_W+1].
  - Else: man = prod[2*MAN_W-1:MAN_W].
  - Rounding is truncation (round toward zero).
  - If s >= 2**EXP_W-1 -> {sign, all-ones, 0}, ovf=1.
  - Else if s <= 0 -> {sign, 0, 0}, unf=1.
  - Else {sign, s[EXP_W-1:0], man}.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_ready, go to IDLE next edge. out_valid drops and in_ready rises together.
  - No accept occurs in the same cycle as the DONE handshake.
- Output updates: result and flags are registered and update only on entry to DONE. Flags are cleared on each new accept.
- Latency, counted in rising edges after the accept edge until out_valid is high:
  - Normal path: MAN_W+3 (26).
  - Special path: 1.
- Backpressure: DONE holds indefinitely while out_ready=0. in_ready stays 0 throughout.
- in_valid outside IDLE is ignored; a and b are not sampled.

Decomposition:
- Package fp_pkg holds:
  - EXP_W, MAN_W, BIAS and the derived widths.
  - The state enum {IDLE, EXP, MUL, NORM, DONE}.
  - The canonical-NaN constant.
  - Operand-class codes (ZERO, NORM, INF, NAN).
- One natural sub-module, fp_exp_add: combinational biased add (eA+eB-BIAS, signed) plus the range compare used in NORM. The FSM and mantissa datapath stay in fp_mul_seq.

Test Plan:
- Basic: a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> result=0x40400000, flags 0, out_valid high 26 edges after accept.
- Normalisation carry: a=b=0x3FC00000 (1.5*1.5) -> result=0x40100000, exponent incremented in NORM, flags 0.
- Overflow and underflow:
  - a=b=0x7F000000 -> result=0x7F800000, ovf=1.
  - a=b=0x00800000 -> result=0x00000000, unf=1.
- Specials (each out_valid after 1 edge):
  - a=0x7F800000, b=0x00000000 -> 0x7FC00000, inv=1.
  - a=0xFF800000, b=0x40000000 -> 0xFF800000, no flags.
  - a=0x80000000, b=0x3F800000 -> 0x80000000, no flags.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next edge.
- Reset mid-MUL: rst=1 for one edge at counter=10 -> IDLE next edge, out_valid=0, outputs zero. A following 1.5*2.0 completes correctly in 26 edges.
